// File: rtl/dds_btn_wave_sel.sv
// Push-button conditioner for the DDS core: synchronise, debounce press/release, step the waveform select.
// Optional long-press reset-to-zero of the select is enabled by defining DDS_BTN_LONGPRESS_EN.
module dds_btn_wave_sel #(
  parameter int DEB_CYCLES  = 20,
  parameter int NUM_WAVES   = 4,
  parameter int SEL_W       = 2,
  parameter int LONG_CYCLES = 100000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             iExtBtn,
  output logic [SEL_W-1:0] oWaveSel,
  output logic             oSelStb,
  output logic             oBtnDb
);

  localparam int CNT_MAX = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DEB_C    = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_WAVES - 1);
`ifdef DDS_BTN_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             btn_p0, btn_p1;
  logic             rel_pend, rel_pend_nxt;
  logic             db_nxt;
  logic             do_adv, do_clr;
`ifdef DDS_BTN_LONGPRESS_EN
  logic             long_done, long_done_nxt;
`endif

  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur);
    return (cur == LAST_SEL) ? '0 : cur + 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchroniser; btn_p1 is the only copy the FSM looks at.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_p0 <= 1'b1;
      btn_p1 <= 1'b1;
    end else begin
      btn_p0 <= iExtBtn;
      btn_p1 <= btn_p0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      rel_pend <= 1'b1;
`ifdef DDS_BTN_LONGPRESS_EN
      long_done <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rel_pend <= rel_pend_nxt;
`ifdef DDS_BTN_LONGPRESS_EN
      long_done <= long_done_nxt;
`endif
    end
  end

  // After reset a full release debounce is required (rel_pend) so a held button cannot advance.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rel_pend_nxt = rel_pend;
    db_nxt       = oBtnDb;
    do_adv       = 1'b0;
    do_clr       = 1'b0;
`ifdef DDS_BTN_LONGPRESS_EN
    long_done_nxt = long_done;
`endif
    case (state)
      IDLE: begin
        if (rel_pend) begin
          if (!btn_p1) begin
            cnt_nxt = '0;
          end else if (cnt == DEB_C) begin
            rel_pend_nxt = 1'b0;
            cnt_nxt      = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (!btn_p1) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = ONE_C;
        end
      end
      PRESS_CHK: begin
        if (btn_p1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_C) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          db_nxt    = 1'b1;
          do_adv    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (btn_p1) begin
          state_nxt = RELEASE_CHK;
          cnt_nxt   = ONE_C;
        end
`ifdef DDS_BTN_LONGPRESS_EN
        else if (!long_done) begin
          if (cnt == LONG_LAST) begin
            do_clr        = 1'b1;
            long_done_nxt = 1'b1;
          end
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      RELEASE_CHK: begin
        if (!btn_p1) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == DEB_C) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          db_nxt    = 1'b0;
`ifdef DDS_BTN_LONGPRESS_EN
          long_done_nxt = 1'b0;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Stage p2: registered outputs; the strobe marks the cycle right after each select change.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      oWaveSel <= '0;
      oSelStb  <= 1'b0;
      oBtnDb   <= 1'b0;
    end else begin
      oBtnDb  <= db_nxt;
      oSelStb <= do_adv | do_clr;
      if (do_clr) begin
        oWaveSel <= '0;
      end else if (do_adv) begin
        oWaveSel <= next_sel(oWaveSel);
      end
    end
  end

endmodule

// File: tb/tb_dds_btn_wave_sel.sv
// Scoreboard bench for dds_btn_wave_sel: run-length reference model predicts strobes, a monitor checks them.
module tb_dds_btn_wave_sel;

  localparam int DEB  = 20;
  localparam int NUMW = 4;
  localparam int LONG = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [1:0] wave_sel;
  logic       sel_stb;
  logic       btn_db;

  dds_btn_wave_sel #(
    .DEB_CYCLES (DEB),
    .NUM_WAVES  (NUMW),
    .SEL_W      (2),
    .LONG_CYCLES(LONG)
  ) dut (
    .CLK     (clk),
    .RESET   (rst),
    .iExtBtn (btn),
    .oWaveSel(wave_sel),
    .oSelStb (sel_stb),
    .oBtnDb  (btn_db)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          wave;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int unsigned cyc      = 0;
  bit          chk_en   = 1'b0;
  int          stb_cnt  = 0;
  int unsigned last_stb_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Reference model: 2-sample delay line, then a run-length debouncer on the pressed level.
  bit h1 = 1'b1, h2 = 1'b1;
  bit lvl = 1'b0, qual = 1'b0, lflag = 1'b0;
  int run = 0, hold = 0, m_wave = 0;

  always @(posedge clk) begin
    bit s, ps;
    cyc++;
    if (rst) begin
      h1 = 1'b1; h2 = 1'b1; lvl = 1'b0; qual = 1'b0; lflag = 1'b0;
      run = 0; hold = 0; m_wave = 0;
    end else begin
      s  = h2;
      h2 = h1;
      h1 = btn;
      ps = !s;
      if (!qual) begin
        run = s ? run + 1 : 0;
        if (run == DEB + 1) begin
          qual = 1'b1;
          run  = 0;
        end
      end else begin
        if (ps != lvl) begin
          run++;
        end else begin
          if (lvl) hold = (run != 0) ? 0 : hold + 1;
          run = 0;
        end
        if (run == DEB + 1) begin
          lvl  = !lvl;
          run  = 0;
          hold = 0;
          if (lvl) begin
            m_wave = (m_wave + 1) % NUMW;
            exp_q.push_back('{m_wave, cyc});
          end else begin
            lflag = 1'b0;
          end
        end
`ifdef DDS_BTN_LONGPRESS_EN
        if (lvl && ps && hold == LONG && !lflag) begin
          lflag  = 1'b1;
          m_wave = 0;
          exp_q.push_back('{m_wave, cyc});
        end
`endif
      end
    end
  end

  // Monitor: pops the scoreboard whenever a strobe is due or seen, and tracks levels every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("stb_present", 32'(sel_stb), 32'd1);
        check("stb_wave", 32'(wave_sel), 32'(exp_q[0].wave));
        void'(exp_q.pop_front());
      end else begin
        check("stb_absent", 32'(sel_stb), 32'd0);
      end
      check("wave_level", 32'(wave_sel), 32'(m_wave));
      check("btn_db", 32'(btn_db), 32'(lvl));
      if (sel_stb === 1'b1) begin
        stb_cnt++;
        last_stb_cyc = cyc;
      end
    end
  end

  task automatic drive(input logic v, input int n);
    btn = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    int unsigned fall_cyc;
    int exp_seq[4];
    bit found;
    rst = 1'b1;
    btn = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    check("rst_wave", 32'(wave_sel), 32'd0);
    check("rst_stb", 32'(sel_stb), 32'd0);
    check("rst_db", 32'(btn_db), 32'd0);

    // Idle after reset
    drive(1'b1, 1000);
    check("s1_wave", 32'(wave_sel), 32'd0);
    check("s1_pulses", 32'(stb_cnt), 32'd0);

    // Clean press with latency check
    base     = stb_cnt;
    fall_cyc = cyc;
    drive(1'b0, 25);
    drive(1'b1, 40);
    check("s2_wave", 32'(wave_sel), 32'd1);
    check("s2_pulses", 32'(stb_cnt - base), 32'd1);
    check("s2_latency", 32'(last_stb_cyc - fall_cyc), 32'(DEB + 3));
    check("s2_db", 32'(btn_db), 32'd0);

    // Glitch rejection
    base = stb_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 10);
      drive(1'b1, 20);
    end
    check("s3_wave", 32'(wave_sel), 32'd1);
    check("s3_pulses", 32'(stb_cnt - base), 32'd0);

    // Wrap with release bounce
    do_reset();
    drive(1'b1, 30);
    base = stb_cnt;
    exp_seq = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 25);
      drive(1'b1, 3);
      drive(1'b0, 3);
      drive(1'b1, 3);
      drive(1'b0, 3);
      drive(1'b1, 30);
      check("s4_wave", 32'(wave_sel), 32'(exp_seq[i]));
    end
    check("s4_pulses", 32'(stb_cnt - base), 32'd4);

    // Reset in the middle of a press check
    btn   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (int'(dut.state) == 1 && int'(dut.cnt) == 10) found = 1'b1;
    end
    check("s5_reach_cnt10", 32'(found), 32'd1);
    do_reset();
    base = stb_cnt;
    drive(1'b0, 200);
    check("s5_held_wave", 32'(wave_sel), 32'd0);
    check("s5_held_pulses", 32'(stb_cnt - base), 32'd0);
    drive(1'b1, 30);
    drive(1'b0, 25);
    drive(1'b1, 30);
    check("s5_after_wave", 32'(wave_sel), 32'd1);

    // Long hold from select 2
    drive(1'b0, 25);
    drive(1'b1, 30);
    check("s6_start_wave", 32'(wave_sel), 32'd2);
    base = stb_cnt;
    drive(1'b0, LONG + 500);
    drive(1'b1, 40);
`ifdef DDS_BTN_LONGPRESS_EN
    check("s6_pulses", 32'(stb_cnt - base), 32'd2);
    check("s6_wave", 32'(wave_sel), 32'd0);
`else
    check("s6_pulses", 32'(stb_cnt - base), 32'd1);
    check("s6_wave", 32'(wave_sel), 32'd3);
`endif

    // Randomised presses, bounces and occasional resets
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 14) == 0) do_reset();
      drive(1'b0, $urandom_range(1, 40));
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b1, $urandom_range(1, 4));
        drive(1'b0, $urandom_range(1, 30));
      end
      drive(1'b1, $urandom_range(1, 40));
      if ($urandom_range(0, 2) == 0) begin
        drive(1'b0, $urandom_range(1, 4));
        drive(1'b1, $urandom_range(20, 40));
      end
    end

    drive(1'b1, 60);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dds_btn_wave_sel.md
Name: dds_btn_wave_sel

Overview:
- Upstream control stage for the DDS core.
- Conditions the raw active-low push-button on iExtBtn: synchronises it, debounces both press and release, and detects a press.
- Each accepted press advances a waveform-select register that the DDS core uses to pick its phase-to-amplitude table.
- Gives the DDS core a single clean 1-cycle strobe per selection change, so the core never sees contact bounce.

Parameters:
- DEB_CYCLES, 20: consecutive stable samples needed to accept a press or release. Minimum 1. At 50 MHz this is 400 ns.
- NUM_WAVES, 4: number of selectable waveforms (0 sine, 1 square, 2 triangle, 3 saw). Range 2..2^SEL_W.
- SEL_W, 2: width of oWaveSel.
- LONG_CYCLES, 100000: hold time of a long press, used only with the optional feature. Must be greater than DEB_CYCLES.

Ports:
- CLK, input, 1: system clock. All logic is on the rising edge.
- RESET, input, 1: synchronous reset, active-high.
- iExtBtn, input, 1: raw button, asynchronous, active-low (0 = pressed).
- oWaveSel, output, SEL_W: current waveform select, registered.
- oSelStb, output, 1: 1-cycle pulse on every change of oWaveSel.
- oBtnDb, output, 1: debounced button level, active-high (1 = pressed), registered.

Behaviour:
- Interface: one clock, CLK. Reset is RESET, synchronous and active-high.
- Reset values:
  - Both synchroniser flops = 1 (released).
  - State = IDLE, counter = 0.
  - oWaveSel = 0, oSelStb = 0, oBtnDb = 0.
  - RESET asserted mid-press or mid-count aborts the operation. A button still held when reset releases must first pass through a full release debounce before it can be accepted as a new press, so it never advances oWaveSel.
- Synchroniser: two flops on iExtBtn. The FSM uses only the second flop output, called s.
- Counter: one shared counter, width $clog2(max(DEB_CYCLES, LONG_CYCLES) + 1).
- FSM states and transitions:
  - IDLE: if s = 0, go to PRESS_CHK and set counter = 1.
  - PRESS_CHK:
    - If s = 1, return to IDLE (glitch rejected, no output change).
    - Else if counter == DEB_CYCLES, go to PRESSED, set oBtnDb = 1, advance oWaveSel and pulse oSelStb.
    - Else increment counter.
  - PRESSED: if s = 1, go to RELEASE_CHK and set counter = 1.
  - RELEASE_CHK:
    - If s = 0, return to PRESSED (bounce ignored; no new advance).
    - Else if counter == DEB_CYCLES, go to IDLE and set oBtnDb = 0.
    - Else increment counter.
  - A stuck-pressed button stays in PRESSED indefinitely and advances exactly once.
- Acceptance and latency:
  - A press is accepted only if iExtBtn is sampled low on DEB_CYCLES+1 consecutive edges.
  - Numbering edge 1 as the first edge that samples iExtBtn low, oWaveSel, oSelStb and oBtnDb change on edge DEB_CYCLES+3.
- Advance rule:
  - oWaveSel becomes oWaveSel+1, wrapping to 0 when oWaveSel == NUM_WAVES-1.
  - Values at or above NUM_WAVES are never produced.
- oSelStb is high for exactly the one cycle after each change of oWaveSel, and 0 otherwise.
- The bench may use hierarchical references to the internal state encoding.

Optional Feature:
- Macro: DDS_BTN_LONGPRESS_EN.
- With the macro defined:
  - In PRESSED the counter keeps counting while s = 0.
  - When it reaches LONG_CYCLES: oWaveSel is forced to 0 and oSelStb pulses for 1 cycle, even if oWaveSel was already 0.
  - A per-press flag blocks any further long-press action until the next IDLE.
  - A bounce back into PRESSED from RELEASE_CHK restarts the long-press count; the flag still blocks a second action.
- Without the macro: the counter is idle in PRESSED, and a long hold has no effect beyond the single advance.

Test Plan:
All scenarios use a 50 MHz CLK and default parameters.
1. Reset then idle: RESET high for 2 cycles, iExtBtn = 1 -> oWaveSel = 0, oSelStb = 0, oBtnDb = 0 with no change for 1000 cycles.
2. Clean press: iExtBtn low for 500 ns (25 cycles) -> oWaveSel goes 0→1 on edge 23 after the fall; exactly one oSelStb pulse; oBtnDb returns to 0 about 21 cycles after release.
3. Glitch rejection: low pulses of 200 ns (10 cycles), 20 cycles apart, repeated 5 times -> oWaveSel unchanged, no oSelStb pulse.
4. Wrap and bounce: 4 clean presses, each with 3-cycle low bounces during release -> oWaveSel goes 1,2,3,0 and exactly 4 oSelStb pulses.
5. Reset mid-press: assert RESET at counter = 10 in PRESS_CHK while iExtBtn stays low -> oWaveSel = 0 and no advance until iExtBtn goes high for at least 21 samples and a new press follows.
6. With DDS_BTN_LONGPRESS_EN defined and oWaveSel = 2: hold iExtBtn low for 2.5 ms -> first advance to 3, then 0 at LONG_CYCLES, giving 2 oSelStb pulses total. Without the macro: oWaveSel stays at 3 and only 1 pulse occurs.
